machine_timer: RTL and testbench

//  Memory-mapped RISC-V machine timer holding 64-bit mtime and mtimecmp. Drives the

---
 rtl/machine_timer_if.sv | 13 +
 rtl/machine_timer.sv | 124 ++++++++++++
 tb/tb_machine_timer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/machine_timer_if.sv
// Data-bus bundle for the machine timer slave: one outstanding request,
// answered by a single-cycle ack carrying the read data.
interface machine_timer_if;
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler, hi-word snapshot
// for tear-free reads, and a registered level IRQ towards the CSR unit.
module machine_timer #(
   parameter int          PRESCALE_W = 8,
   parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic           clk,
   input  logic           rst_n,
   machine_timer_if.slave bus,
   output logic           timer_overflow
);
   typedef enum logic {IDLE, RESP} busState_e;

   busState_e             state_q, state_d;
   logic [63:0]           mtime_q, mtime_d;
   logic [63:0]           mtimeCmp_q, mtimeCmp_d;
   logic [31:0]           shadow_q, shadow_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  en_q, en_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] prescCnt_q, prescCnt_d;
   logic                  overflow_q, overflow_d;

   logic                  start;
   logic                  doWrite;
   logic                  doRead;
   logic                  tick;
   logic [2:0]            regSel;
   logic [31:0]           ctrlView;
   logic                  unusedAddr;

   assign start      = (state_q == IDLE) && bus.req;
   assign doWrite    = start && bus.we;
   assign doRead     = start && !bus.we;
   assign regSel     = bus.addr[4:2];
   assign unusedAddr = ^bus.addr[1:0];
   assign tick       = en_q && (prescCnt_q == prescale_q);

   assign bus.ack        = (state_q == RESP);
   assign bus.rdata      = rdata_q;
   assign timer_overflow = overflow_q;

   always_comb begin
      ctrlView                    = '0;
      ctrlView[0]                 = en_q;
      ctrlView[8 +: PRESCALE_W]   = prescale_q;
   end

   // A request is taken only from IDLE, so a req still high during ack is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A bus write to an mtime half overrides the tick on the same edge, so that tick is lost.
   always_comb begin
      mtime_d    = mtime_q + {63'd0, tick};
      mtimeCmp_d = mtimeCmp_q;
      shadow_d   = shadow_q;
      rdata_d    = rdata_q;
      en_d       = en_q;
      prescale_d = prescale_q;
      prescCnt_d = (en_q && !tick) ? prescCnt_q + 1'b1 : '0;
      overflow_d = en_q && (mtime_q >= mtimeCmp_q);

      if (doWrite) begin
         case (regSel)
            3'd0: mtime_d = {mtime_q[63:32], bus.wdata};
            3'd1: mtime_d = {bus.wdata, mtime_q[31:0]};
            3'd2: mtimeCmp_d[31:0]  = bus.wdata;
            3'd3: mtimeCmp_d[63:32] = bus.wdata;
            3'd4: begin
               en_d       = bus.wdata[0];
               prescale_d = bus.wdata[8 +: PRESCALE_W];
               prescCnt_d = '0;
            end
            default: ;
         endcase
      end

      if (doRead) begin
         case (regSel)
            3'd0: begin
               rdata_d  = mtime_q[31:0];
               shadow_d = mtime_q[63:32];
            end
            3'd1:    rdata_d = shadow_q;
            3'd2:    rdata_d = mtimeCmp_q[31:0];
            3'd3:    rdata_d = mtimeCmp_q[63:32];
            3'd4:    rdata_d = ctrlView;
            3'd5:    rdata_d = {31'd0, overflow_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mtime_q    <= '0;
         mtimeCmp_q <= CMP_RESET;
         shadow_q   <= '0;
         rdata_q    <= '0;
         en_q       <= 1'b0;
         prescale_q <= '0;
         prescCnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mtime_q    <= mtime_d;
         mtimeCmp_q <= mtimeCmp_d;
         shadow_q   <= shadow_d;
         rdata_q    <= rdata_d;
         en_q       <= en_d;
         prescale_q <= prescale_d;
         prescCnt_q <= prescCnt_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_machine_timer.sv
// Directed plus randomized bench for machine_timer, checked every cycle against
// a cycle-counting reference model of the timer's register behaviour.
module tb_machine_timer;
   logic clk;
   logic rst_n;
   logic timerOverflow;
   int   compared;
   int   mismatched;

   machine_timer_if bus ();

   machine_timer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .timer_overflow (timerOverflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] mTime;
   logic [63:0] mCmp;
   logic [31:0] mShadow;
   logic [31:0] mRdata;
   logic        mEn;
   int          mPresc;
   int          mCnt;
   logic        mBusy;
   logic        mIrq;

   function automatic void modelReset();
      mTime   = 64'd0;
      mCmp    = 64'hFFFF_FFFF_FFFF_FFFF;
      mShadow = 32'd0;
      mRdata  = 32'd0;
      mEn     = 1'b0;
      mPresc  = 0;
      mCnt    = 0;
      mBusy   = 1'b0;
      mIrq    = 1'b0;
   endfunction

   // mCnt counts enabled cycles since the last ctrl write; every (prescale+1)-th one ticks.
   function automatic void modelStep();
      logic        start;
      logic        tickNow;
      logic        newIrq;
      logic [63:0] nextTime;
      int          newCnt;
      start    = bus.req && !mBusy;
      newIrq   = mEn && (mTime >= mCmp);
      tickNow  = mEn && (((mCnt + 1) % (mPresc + 1)) == 0);
      nextTime = tickNow ? mTime + 64'd1 : mTime;
      newCnt   = mEn ? mCnt + 1 : 0;
      if (start && bus.we) begin
         case (bus.addr[4:2])
            3'd0: nextTime = {mTime[63:32], bus.wdata};
            3'd1: nextTime = {bus.wdata, mTime[31:0]};
            3'd2: mCmp[31:0]  = bus.wdata;
            3'd3: mCmp[63:32] = bus.wdata;
            3'd4: begin
               mEn    = bus.wdata[0];
               mPresc = int'(bus.wdata[15:8]);
               newCnt = 0;
            end
            default: ;
         endcase
      end
      if (start && !bus.we) begin
         case (bus.addr[4:2])
            3'd0: begin
               mRdata  = mTime[31:0];
               mShadow = mTime[63:32];
            end
            3'd1:    mRdata = mShadow;
            3'd2:    mRdata = mCmp[31:0];
            3'd3:    mRdata = mCmp[63:32];
            3'd4:    mRdata = {16'd0, 8'(mPresc), 7'd0, mEn};
            3'd5:    mRdata = {31'd0, mIrq};
            default: mRdata = 32'd0;
         endcase
      end
      mTime = nextTime;
      mCnt  = newCnt;
      mBusy = start;
      mIrq  = newIrq;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("ack", {63'd0, bus.ack}, {63'd0, mBusy});
      checkOutput("irq", {63'd0, timerOverflow}, {63'd0, mIrq});
   endtask

   // One bus transaction; req is sometimes left high through the ack cycle to show it is ignored.
   task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data,
                                output logic [31:0] rd);
      bus.req   = 1'b1;
      bus.we    = we;
      bus.addr  = addr;
      bus.wdata = data;
      stepClock();
      rd = bus.rdata;
      if (!we) checkOutput($sformatf("rdata@%02h", addr), {32'd0, bus.rdata}, {32'd0, mRdata});
      bus.req = 1'($urandom_range(0, 1));
      stepClock();
      bus.req = 1'b0;
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      bus.req = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic readAll();
      logic [31:0] rd;
      for (int a = 0; a < 6; a++) applyStimulus(1'b0, 5'(a * 4), 32'd0, rd);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] first;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        sawIrq;
      compared   = 0;
      mismatched = 0;
      bus.req    = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = 5'd0;
      bus.wdata  = 32'd0;
      rst_n      = 1'b0;
      modelReset();
      #1;
      doReset();

      $display("[TB] reset values");
      checkOutput("rst_irq", {63'd0, timerOverflow}, 64'd0);
      checkOutput("rst_ack", {63'd0, bus.ack}, 64'd0);
      applyStimulus(1'b0, 5'h08, 32'd0, rd);
      checkOutput("rst_cmp_lo", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);
      readAll();

      $display("[TB] compare and IRQ");
      applyStimulus(1'b1, 5'h08, 32'h10, rd);
      applyStimulus(1'b1, 5'h0C, 32'h0, rd);
      applyStimulus(1'b1, 5'h10, 32'h001, rd);
      sawIrq = 1'b0;
      for (int i = 0; i < 30; i++) begin
         stepClock();
         sawIrq = sawIrq | timerOverflow;
      end
      checkOutput("irq_rose", {63'd0, sawIrq}, 64'd1);
      applyStimulus(1'b0, 5'h14, 32'd0, rd);
      applyStimulus(1'b1, 5'h08, 32'h100, rd);
      checkOutput("irq_fell", {63'd0, timerOverflow}, 64'd0);

      $display("[TB] prescaler");
      applyStimulus(1'b1, 5'h10, 32'h0, rd);
      applyStimulus(1'b1, 5'h00, 32'h0, rd);
      applyStimulus(1'b1, 5'h10, 32'h301, rd);
      applyStimulus(1'b0, 5'h00, 32'd0, first);
      repeat (38) stepClock();
      applyStimulus(1'b0, 5'h00, 32'd0, rd);
      checkOutput("presc_40clk", {32'd0, rd - first}, 64'd10);
      applyStimulus(1'b1, 5'h10, 32'h0, rd);
      applyStimulus(1'b0, 5'h00, 32'd0, first);
      repeat (10) stepClock();
      applyStimulus(1'b0, 5'h00, 32'd0, rd);
      checkOutput("frozen", {32'd0, rd - first}, 64'd0);

      $display("[TB] snapshot");
      applyStimulus(1'b1, 5'h04, 32'h0, rd);
      applyStimulus(1'b1, 5'h00, 32'hFFFF_FFFF, rd);
      applyStimulus(1'b1, 5'h10, 32'h1, rd);
      applyStimulus(1'b0, 5'h00, 32'd0, lo);
      applyStimulus(1'b0, 5'h04, 32'd0, hi);
      checkOutput("no_tear", {63'd0, ({hi, lo} == 64'd0)}, 64'd0);

      $display("[TB] wrap");
      doReset();
      applyStimulus(1'b1, 5'h04, 32'hFFFF_FFFF, rd);
      applyStimulus(1'b1, 5'h00, 32'hFFFF_FFFF, rd);
      applyStimulus(1'b1, 5'h10, 32'h1, rd);
      repeat (4) stepClock();
      applyStimulus(1'b0, 5'h00, 32'd0, lo);
      applyStimulus(1'b0, 5'h04, 32'd0, hi);
      checkOutput("wrapped_hi", {32'd0, hi}, 64'd0);

      $display("[TB] reset mid-transaction");
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 5'h00;
      #3;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("midrst_ack", {63'd0, bus.ack}, 64'd0);
      bus.req = 1'b0;
      doReset();
      readAll();

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1: applyStimulus(1'b1, 5'h10,
                     (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 3) != 0), rd);
            2:    applyStimulus(1'b1, 5'h08, mTime[31:0] + 32'($urandom_range(0, 40)), rd);
            3:    applyStimulus(1'b1, 5'h0C, mTime[63:32] + 32'($urandom_range(0, 1)), rd);
            4:    applyStimulus(1'b1, 5'(4 * $urandom_range(0, 1)),
                     ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom, rd);
            5, 6, 7: applyStimulus(1'b0, 5'($urandom_range(0, 31)), 32'd0, rd);
            8:    applyStimulus(1'b1, 5'($urandom_range(20, 31)), $urandom, rd);
            default: repeat ($urandom_range(1, 4)) stepClock();
         endcase
      end
      readAll();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
